// File: rtl/core2wb_pipelined.sv
// Core-to-Wishbone pipelined bridge.
// Handshake: a core request is accepted in the cycle where core_req and core_gnt
// are both high (core_gnt = wb_stb & ~wb_stall); a response is delivered to the
// core in the cycle where core_rvalid is high, with core_err qualifying it.
// Up to MAX_OUT transactions may be outstanding; responses return in Wishbone order.
// A response-free stretch of TIMEOUT busy cycles aborts all outstanding
// transactions with one error response per cycle.
module core2wb_pipelined #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // core side
    input  logic                           core_req,
    output logic                           core_gnt,
    output logic                           core_rvalid,
    output logic                           core_err,
    input  logic [AW-1:0]                  core_addr,
    input  logic                           core_we,
    input  logic [DW/8-1:0]                core_be,
    input  logic [DW-1:0]                  core_wdata,
    output logic [DW-1:0]                  core_rdata,
    // wishbone side
    output logic                           wb_cyc,
    output logic                           wb_stb,
    output logic [AW-1:0]                  wb_adr,
    output logic [DW-1:0]                  wb_dat_o,
    output logic                           wb_we,
    output logic [DW/8-1:0]                wb_sel,
    input  logic [DW-1:0]                  wb_dat_i,
    input  logic                           wb_ack,
    input  logic                           wb_err,
    input  logic                           wb_stall,
    // debug visibility of the control state
    output logic [1:0]                     dbg_state,
    output logic [$clog2(MAX_OUT+1)-1:0]   dbg_cnt
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          in_abort;
    logic          stb;
    logic          accept;
    logic          resp;
    logic          abort_rsp;
    logic          timeout;

    // Request issue and response detection; every handshake output is gated by
    // rst_n so reset silences the bus without waiting for a clock edge.
    assign in_abort  = (state_q == ABORT);
    assign stb       = rst_n & ~in_abort & core_req & (cnt_q < CNT_MAX);
    assign accept    = stb & ~wb_stall;
    assign resp      = rst_n & ~in_abort & (wb_ack | wb_err) & (cnt_q != '0);
    assign abort_rsp = rst_n & in_abort & (cnt_q != '0);

    assign wb_stb      = stb;
    assign core_gnt    = accept;
    assign wb_cyc      = rst_n & ~in_abort & (stb | (cnt_q != '0));
    assign core_rvalid = resp | abort_rsp;
    assign core_err    = (resp & wb_err) | abort_rsp;

    assign wb_adr     = core_addr;
    assign wb_dat_o   = core_wdata;
    assign wb_we      = core_we;
    assign wb_sel     = core_we ? core_be : '1;
    assign core_rdata = wb_dat_i;

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // Next-state logic: outstanding counter, no-response timer and FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = '0;
        timeout = 1'b0;

        if (abort_rsp)
            cnt_d = cnt_q - 1'b1;
        else if (accept && !resp)
            cnt_d = cnt_q + 1'b1;
        else if (resp && !accept)
            cnt_d = cnt_q - 1'b1;

        // A genuine response in the final timer cycle wins: resp keeps this branch off.
        if (TIMEOUT != 0 && state_q == BUSY && !resp && cnt_q != '0) begin
            if (tmr_q == TMR_LAST)
                timeout = 1'b1;
            else
                tmr_d = tmr_q + 1'b1;
        end

        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY: begin
                if (timeout)
                    state_d = ABORT;
                else if (cnt_d == '0)
                    state_d = IDLE;
            end
            ABORT:   if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards all outstanding transactions silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: tb/tb_core2wb_pipelined.sv
// Self-checking bench for core2wb_pipelined (MAX_OUT=2, TIMEOUT=8).
module tb_core2wb_pipelined;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req, core_gnt, core_rvalid, core_err;
  logic [AW-1:0] core_addr;
  logic          core_we;
  logic [SW-1:0] core_be;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [SW-1:0] wb_sel;
  logic [1:0]    dbg_state;
  logic [1:0]    dbg_cnt;

  int checks = 0;
  int errors = 0;

  // expected response: {check_data, err, data}
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] exp_e;

  core2wb_pipelined #(.AW(AW), .DW(DW), .MAX_OUT(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_err(core_err), .core_addr(core_addr), .core_we(core_we),
    .core_be(core_be), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .wb_err(wb_err), .wb_stall(wb_stall),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rsp(input logic err, input logic [DW-1:0] d);
    exp_q.push_back({1'b1, err, d});
  endtask

  task automatic push_abort();
    exp_q.push_back({1'b1 ^ 1'b1, 1'b1, {DW{1'b0}}});
  endtask

  // drive one Wishbone response with fresh random data and record what the core must see
  task automatic wb_respond(input logic a, input logic e);
    wb_ack   = a;
    wb_err   = e;
    wb_dat_i = $urandom;
    push_rsp(e, wb_dat_i);
  endtask

  // scoreboard: every core response is matched against the expected queue
  always @(negedge clk) begin
    if (core_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rvalid err=%0b, expected no response", core_err);
      end else begin
        exp_e = exp_q.pop_front();
        if (core_err !== exp_e[DW] || (exp_e[DW+1] && core_rdata !== exp_e[DW-1:0])) begin
          errors++;
          $display("FAIL rsp_match: got err=%0b data=%0h expected err=%0b data=%0h",
                   core_err, core_rdata, exp_e[DW], exp_e[DW-1:0]);
        end
      end
    end
  end

  typedef struct {
    logic          we;
    logic [SW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] dati;
    logic [SW-1:0] exp_sel;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int busy_n;
    int pulses;
    logic seen_abort;
    logic idle_seen;
    logic [3:0] gnt_pat;

    vecs[0] = '{1'b1, 4'b0011, 32'h1000_0004, 32'hdead_beef, 32'h1234_5678, 4'b0011};
    vecs[1] = '{1'b0, 4'b0011, 32'h2000_0008, 32'h0bad_f00d, 32'h8765_4321, 4'b1111};
    vecs[2] = '{1'b1, 4'b1000, 32'hffff_fffc, 32'h0000_0001, 32'ha5a5_5a5a, 4'b1000};
    vecs[3] = '{1'b0, 4'b0000, 32'h0000_0000, 32'hffff_ffff, 32'h0000_0000, 4'b1111};

    // reset block: drive activity during reset, outputs must stay quiet
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_be = '1; core_addr = '0; core_wdata = '0;
    wb_dat_i = '0; wb_ack = 1'b1; wb_err = 1'b0; wb_stall = 1'b0;
    #3;
    check("rst_stb", wb_stb, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_gnt", core_gnt, 0);
    check("rst_rvalid", core_rvalid, 0);
    check("rst_err", core_err, 0);
    check("rst_cnt", dbg_cnt, 0);
    check("rst_state", dbg_state, S_IDLE);
    repeat (2) @(posedge clk);
    #1;
    core_req = 1'b0; wb_ack = 1'b0; rst_n = 1'b1;
    #2;
    check("post_rst_cyc", wb_cyc, 0);

    // table-driven pass-through vectors (no request pending)
    for (int i = 0; i < 4; i++) begin
      tick();
      core_we = vecs[i].we; core_be = vecs[i].be; core_addr = vecs[i].addr;
      core_wdata = vecs[i].wdata; wb_dat_i = vecs[i].dati;
      #2;
      check("vec_adr", wb_adr, vecs[i].addr);
      check("vec_dat_o", wb_dat_o, vecs[i].wdata);
      check("vec_we", wb_we, vecs[i].we);
      check("vec_sel", wb_sel, vecs[i].exp_sel);
      check("vec_rdata", core_rdata, vecs[i].dati);
      check("vec_idle_cyc", wb_cyc, 0);
    end

    // three back-to-back reads, first acked in the third cycle
    gnt_pat = 4'b1011;
    core_we = 1'b0; core_be = '1;
    for (int c = 0; c < 4; c++) begin
      tick();
      core_req = 1'b1;
      if (c == 2) wb_respond(1'b1, 1'b0);
      else wb_ack = 1'b0;
      #2;
      check("b2b_gnt", core_gnt, gnt_pat[c]);
      check("b2b_cnt_le_max", dbg_cnt <= 2, 1);
    end
    tick(); core_req = 1'b0; wb_respond(1'b1, 1'b0);
    #2;
    check("b2b_cnt_full", dbg_cnt, 2);
    tick(); wb_respond(1'b1, 1'b0);
    #2;
    check("b2b_cyc_last", wb_cyc, 1);
    tick(); wb_ack = 1'b0;
    #2;
    check("b2b_cnt_done", dbg_cnt, 0);
    check("b2b_cyc_drop", wb_cyc, 0);

    // write with partial byte enables, then a read
    tick(); core_req = 1'b1; core_we = 1'b1; core_be = 4'b0011;
    #2;
    check("wr_sel", wb_sel, 4'b0011);
    check("wr_gnt", core_gnt, 1);
    tick(); core_we = 1'b0;
    #2;
    check("rd_sel", wb_sel, 4'b1111);
    check("rd_gnt", core_gnt, 1);
    tick(); core_req = 1'b0; wb_respond(1'b1, 1'b0);
    tick(); wb_respond(1'b1, 1'b0);
    tick(); wb_ack = 1'b0;
    #2;
    check("wrrd_cnt_done", dbg_cnt, 0);

    // stall holds the request for four cycles
    for (int c = 0; c < 4; c++) begin
      tick(); core_req = 1'b1; wb_stall = 1'b1;
      #2;
      check("stall_stb", wb_stb, 1);
      check("stall_gnt", core_gnt, 0);
      check("stall_cnt", dbg_cnt, 0);
    end
    tick(); wb_stall = 1'b0;
    #2;
    check("stall_release_gnt", core_gnt, 1);
    tick(); core_req = 1'b0; wb_respond(1'b1, 1'b0);
    #2;
    check("stall_one_accept", dbg_cnt, 1);
    tick(); wb_ack = 1'b0;
    #2;
    check("stall_cnt_done", dbg_cnt, 0);

    // ack and err together count as one error response
    tick(); core_req = 1'b1;
    tick(); core_req = 1'b0; wb_respond(1'b1, 1'b1);
    #2;
    check("ackerr_rvalid", core_rvalid, 1);
    check("ackerr_err", core_err, 1);
    tick(); wb_ack = 1'b0; wb_err = 1'b0;
    #2;
    check("ackerr_cnt", dbg_cnt, 0);
    check("ackerr_cyc", wb_cyc, 0);

    // stray ack with nothing outstanding
    tick(); wb_ack = 1'b1;
    #2;
    check("stray_rvalid", core_rvalid, 0);
    tick(); wb_ack = 1'b0;
    #2;
    check("stray_cnt", dbg_cnt, 0);

    // timeout abort with two outstanding reads
    tick(); core_req = 1'b1;
    #2;
    busy_n = 0; seen_abort = 1'b0;
    for (int i = 0; i < 30 && !seen_abort; i++) begin
      tick(); core_req = (i == 0);
      #2;
      if (dbg_state == S_ABORT) seen_abort = 1'b1;
      else if (dbg_state == S_BUSY) busy_n++;
    end
    check("to_reached", seen_abort, 1);
    check("to_busy_cycles", busy_n, 8);
    check("to_cnt_at_abort", dbg_cnt, 2);
    pulses = 0; idle_seen = 1'b0;
    if (seen_abort) begin
      push_abort();
      push_abort();
      // try to issue and ack during abort: both must be ignored
      core_req = 1'b1; wb_ack = 1'b1; wb_dat_i = $urandom;
      #1;
      for (int i = 0; i < 10 && !idle_seen; i++) begin
        if (i > 0) begin tick(); #2; end
        if (dbg_state == S_IDLE) begin
          idle_seen = 1'b1;
          core_req = 1'b0; wb_ack = 1'b0;
        end else begin
          check("abort_cyc", wb_cyc, 0);
          check("abort_stb", wb_stb, 0);
          check("abort_gnt", core_gnt, 0);
          if (core_rvalid && core_err) pulses++;
        end
      end
    end
    core_req = 1'b0; wb_ack = 1'b0;
    check("abort_pulses", pulses, 2);
    check("abort_to_idle", idle_seen, 1);
    tick(); wb_ack = 1'b1;
    #2;
    check("late_ack_rvalid", core_rvalid, 0);
    tick(); wb_ack = 1'b0;
    #2;
    check("late_ack_cnt", dbg_cnt, 0);
    check("late_ack_state", dbg_state, S_IDLE);

    // asynchronous reset with two outstanding
    tick(); core_req = 1'b1;
    tick();
    tick();
    #2;
    check("arst_pre_cnt", dbg_cnt, 2);
    check("arst_pre_cyc", wb_cyc, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_cyc", wb_cyc, 0);
    check("arst_stb", wb_stb, 0);
    check("arst_gnt", core_gnt, 0);
    check("arst_cnt", dbg_cnt, 0);
    tick(); core_req = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); core_req = 1'b1;
    #2;
    check("arst_after_gnt", core_gnt, 1);
    tick(); core_req = 1'b0; wb_respond(1'b1, 1'b0);
    #2;
    check("arst_after_rvalid", core_rvalid, 1);
    tick(); wb_ack = 1'b0;
    #2;
    check("arst_after_cnt", dbg_cnt, 0);

    // final report
    tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
